// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the pipeline
// MEM stage (P, priority) and a secondary master (D: loader/debug/DMA).
// P reads are combinational; D reads return registered one cycle after grant.
// A starvation counter forces one D slot after STARVE_MAX consecutive D waits.
// Optional feature macro: DMEM_ARB_PERF_EN adds perf_pstall_o / perf_dgnt_o.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_IDLE   | no D read response pending
// ST_D_RESP | D read granted last cycle; d_rvalid_o high, d_rdata_o valid
module dmem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p_req_i,
   input  logic                  p_we_i,
   input  logic [DATA_WIDTH-1:0] p_addr_i,
   input  logic [DATA_WIDTH-1:0] p_wdata_i,
   input  logic [1:0]            p_type_i,
   input  logic                  p_sign_i,
   output logic [DATA_WIDTH-1:0] p_rdata_o,
   output logic                  p_stall_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [DATA_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   input  logic [1:0]            d_type_i,
   input  logic                  d_sign_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [1:0]            mem_type_o,
   output logic                  mem_sign_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]           perf_pstall_o,
   output logic [31:0]           perf_dgnt_o
`endif
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {OWN_NONE, OWN_P, OWN_D} owner_t;
   typedef enum logic {ST_IDLE, ST_D_RESP} state_t;

   owner_t                owner;
   logic                  force_d;
   logic                  d_rd_gnt;

   logic [CW-1:0]         starve_d, starve_q;
   state_t                state_d, state_q;
   logic [DATA_WIDTH-1:0] d_rdata_d, d_rdata_q;

   // Port owner and memory-side mux; reset parks the port with no owner.
   always_comb begin
      force_d     = (starve_q == STARVE_LIM) && d_req_i;
      owner       = OWN_NONE;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_type_o  = 2'b00;
      mem_sign_o  = 1'b0;
      d_gnt_o     = 1'b0;
      p_stall_o   = 1'b0;
      if (!rst) begin
         if (p_req_i && !force_d) begin
            owner = OWN_P;
         end else if (d_req_i) begin
            owner = OWN_D;
         end
      end
      case (owner)
         OWN_P: begin
            mem_we_o    = p_we_i;
            mem_addr_o  = p_addr_i;
            mem_wdata_o = p_wdata_i;
            mem_type_o  = p_type_i;
            mem_sign_o  = p_sign_i;
         end
         OWN_D: begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_type_o  = d_type_i;
            mem_sign_o  = d_sign_i;
            d_gnt_o     = 1'b1;
            p_stall_o   = p_req_i;
         end
         default: ;
      endcase
   end

   assign p_rdata_o = mem_rdata_i;

   // Next-state for the starvation counter and the D read-response FSM.
   always_comb begin
      d_rd_gnt = d_gnt_o && !d_we_i;
      if (d_gnt_o || !d_req_i) begin
         starve_d = '0;
      end else if (starve_q == STARVE_LIM) begin
         starve_d = starve_q;
      end else begin
         starve_d = starve_q + CW'(1);
      end
      state_d   = d_rd_gnt ? ST_D_RESP : ST_IDLE;
      d_rdata_d = d_rd_gnt ? mem_rdata_i : d_rdata_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q  <= '0;
         state_q   <= ST_IDLE;
         d_rdata_q <= '0;
      end else begin
         starve_q  <= starve_d;
         state_q   <= state_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // A response pending when reset arrives is suppressed, not delivered.
   assign d_rvalid_o = (state_q == ST_D_RESP) && !rst;
   assign d_rdata_o  = d_rdata_q;

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_pstall_d, perf_pstall_q;
   logic [31:0] perf_dgnt_d, perf_dgnt_q;

   // Event counters, free-running with natural 32-bit wrap.
   always_comb begin
      perf_pstall_d = perf_pstall_q + 32'(p_stall_o);
      perf_dgnt_d   = perf_dgnt_q + 32'(d_gnt_o);
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_pstall_q <= '0;
         perf_dgnt_q   <= '0;
      end else begin
         perf_pstall_q <= perf_pstall_d;
         perf_dgnt_q   <= perf_dgnt_d;
      end
   end

   assign perf_pstall_o = perf_pstall_q;
   assign perf_dgnt_o   = perf_dgnt_q;
`endif

endmodule
